// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
//   Bundles every non-clock signal of the RAM arbiter: the instruction-fetch
//   request/response pair, the load/store request/response pair and the
//   single-port RAM bus.
//
//   slave  : the arbiter's view (takes requests and read data, drives
//            readies, responses and the RAM command).
//   master : the surroundings' view (fetch unit, mem stage and RAM model).
//
//   Signal summary (XLEN = data/address width):
//     if_req_valid/addr, if_req_ready          IF read request handshake
//     if_rsp_valid/rdata                       IF one-cycle response pulse
//     ls_req_valid/addr/wen/wdata/wmask,       LS request handshake
//     ls_req_ready
//     ls_rsp_valid/rdata                       LS one-cycle response pulse
//     ram_addr_o/wen_o/wdata_o/wmask_o         RAM command
//     ram_rdata_i                              RAM read data
// -----------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int XLEN = 64
);
    logic            if_req_valid;
    logic [XLEN-1:0] if_req_addr;
    logic            if_req_ready;
    logic            if_rsp_valid;
    logic [XLEN-1:0] if_rsp_rdata;

    logic            ls_req_valid;
    logic [XLEN-1:0] ls_req_addr;
    logic            ls_req_wen;
    logic [XLEN-1:0] ls_req_wdata;
    logic [1:0]      ls_req_wmask;
    logic            ls_req_ready;
    logic            ls_rsp_valid;
    logic [XLEN-1:0] ls_rsp_rdata;

    logic [XLEN-1:0] ram_addr_o;
    logic            ram_wen_o;
    logic [XLEN-1:0] ram_wdata_o;
    logic [1:0]      ram_wmask_o;
    logic [XLEN-1:0] ram_rdata_i;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output ram_addr_o, ram_wen_o, ram_wdata_o, ram_wmask_o,
        input  ram_rdata_i
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  ram_addr_o, ram_wen_o, ram_wdata_o, ram_wmask_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//   Shares one data-RAM port between instruction fetch (read-only) and the
//   load/store stage (read/write). Round-robin grant, one transaction in
//   flight, fixed RAM read latency RAM_LAT (legal 1..4).
//
//   Transaction timeline (handshake in cycle T):
//     T                  IDLE   : ready to the granted requester, payload latched
//     T+1 .. T+RAM_LAT   ACCESS : address held; write pulse only in T+1 for
//                                 stores; read data sampled in T+RAM_LAT
//     T+RAM_LAT+1        RESP   : one-cycle rsp_valid pulse to the owner
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    ram_arbiter_if.slave (IF/LS request+response, RAM command/data)
//   XLEN must match the width the interface instance was built with.
// -----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int XLEN    = 64,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // Index of the ACCESS cycle in which the RAM data is valid.
    localparam logic [2:0] CNT_LAST = 3'(RAM_LAT - 1);

    state_t          state, state_next;
    owner_t          last_grant, owner;
    logic [2:0]      cnt;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic            wen_q;
    logic [1:0]      wmask_q;
    logic [XLEN-1:0] if_rdata_q, ls_rdata_q;

    logic            grant_if, grant_ls;
    logic            if_ready, ls_ready;

    // -------------------------------------------------------------------------
    // Arbitration: a lone requester wins; on contention the one that did not
    // win last time wins. Readies are only offered in IDLE and never in reset.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_if = bus.if_req_valid && (!bus.ls_req_valid || last_grant == OWN_LS);
        grant_ls = bus.ls_req_valid && (!bus.if_req_valid || last_grant == OWN_IF);
        if_ready = rst_n && (state == IDLE) && grant_if;
        ls_ready = rst_n && (state == IDLE) && grant_ls;
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top of a combinational block covers
    // every path, so no branch can leave the output unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (if_ready || ls_ready) state_next = ACCESS;
            ACCESS:  if (cnt == CNT_LAST)      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: request capture, latency counter, response data registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_LS;   // makes IF the first winner on contention
            owner      <= OWN_IF;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            wmask_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (if_ready) begin
                // Fetch is read-only: force the write controls off.
                addr_q     <= bus.if_req_addr;
                wdata_q    <= '0;
                wen_q      <= 1'b0;
                wmask_q    <= '0;
                owner      <= OWN_IF;
                last_grant <= OWN_IF;
            end else if (ls_ready) begin
                addr_q     <= bus.ls_req_addr;
                wdata_q    <= bus.ls_req_wdata;
                wen_q      <= bus.ls_req_wen;
                wmask_q    <= bus.ls_req_wmask;
                owner      <= OWN_LS;
                last_grant <= OWN_LS;
            end

            if (if_ready || ls_ready) begin
                cnt <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 3'd1;
            end

            // Capture in the last ACCESS cycle; each register then holds until
            // its owner's next response. A store answers with zero data.
            if (state == ACCESS && cnt == CNT_LAST) begin
                if (owner == OWN_IF) begin
                    if_rdata_q <= bus.ram_rdata_i;
                end else begin
                    ls_rdata_q <= wen_q ? '0 : bus.ram_rdata_i;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.if_req_ready = if_ready;
        bus.ls_req_ready = ls_ready;

        // Address and write data simply expose the capture registers, so they
        // hold the last transaction's values outside ACCESS.
        bus.ram_addr_o  = addr_q;
        bus.ram_wdata_o = wdata_q;

        // Write strobe only in the first ACCESS cycle of a store.
        bus.ram_wen_o   = (state == ACCESS) && (cnt == 3'd0) && wen_q;
        bus.ram_wmask_o = bus.ram_wen_o ? wmask_q : 2'b00;

        bus.if_rsp_valid = (state == RESP) && (owner == OWN_IF);
        bus.ls_rsp_valid = (state == RESP) && (owner == OWN_LS);
        bus.if_rsp_rdata = if_rdata_q;
        bus.ls_rsp_rdata = ls_rdata_q;
    end

endmodule
